// File: rtl/perf_job_loader_if.sv
// Byte-stream job input and 32-bit result return for perf_job_loader.
// master: host side (drives bytes, consumes results); slave: loader side.
interface perf_job_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_nonce;
    logic        res_timeout;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  res_valid,
        output res_ready,
        input  res_nonce,
        input  res_timeout
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output res_valid,
        input  res_ready,
        output res_nonce,
        output res_timeout
    );
endinterface

// File: rtl/perf_job_loader.sv
// Job loader: collects a 14-byte frame, runs perf_sys, returns nonce or timeout.
// Ports: clk, reset; bus (frame in / result out); abort; block0..11, target,
// start, busy to perf_sys side; finish, nonce0..3 from perf_sys.
module perf_job_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000,
    parameter int unsigned TW             = 20
) (
    input  logic                clk,
    input  logic                reset,
    perf_job_loader_if.slave    bus,
    input  logic                abort,
    output logic [7:0]          block0,
    output logic [7:0]          block1,
    output logic [7:0]          block2,
    output logic [7:0]          block3,
    output logic [7:0]          block4,
    output logic [7:0]          block5,
    output logic [7:0]          block6,
    output logic [7:0]          block7,
    output logic [7:0]          block8,
    output logic [7:0]          block9,
    output logic [7:0]          block10,
    output logic [7:0]          block11,
    output logic [15:0]         target,
    output logic                start,
    input  logic                finish,
    input  logic [7:0]          nonce0,
    input  logic [7:0]          nonce1,
    input  logic [7:0]          nonce2,
    input  logic [7:0]          nonce3,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 32'd1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [7:0]  block_q [12];
    logic [15:0] target_q;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic [31:0] res_nonce_q;
    logic        res_timeout_q;
    logic        res_valid_q;
    logic        start_q;
    logic        busy_q;

    assign cnt_d = cnt_q + 4'd1;
    assign tmr_d = tmr_q + 1'b1;

    // A byte offered while abort is high must not be taken.
    assign bus.in_ready    = (state_q == S_LOAD) && !abort;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_nonce   = res_nonce_q;
    assign bus.res_timeout = res_timeout_q;

    assign start  = start_q;
    assign busy   = busy_q;
    assign target = target_q;

    assign block0  = block_q[0];
    assign block1  = block_q[1];
    assign block2  = block_q[2];
    assign block3  = block_q[3];
    assign block4  = block_q[4];
    assign block5  = block_q[5];
    assign block6  = block_q[6];
    assign block7  = block_q[7];
    assign block8  = block_q[8];
    assign block9  = block_q[9];
    assign block10 = block_q[10];
    assign block11 = block_q[11];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            cnt_q         <= '0;
            block_q       <= '{default: 8'h00};
            target_q      <= '0;
            tmr_q         <= '0;
            res_nonce_q   <= '0;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else if (abort) begin
            // Header bytes already loaded are kept; the next frame overwrites them.
            state_q       <= S_LOAD;
            cnt_q         <= '0;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (cnt_q < 4'd12) begin
                            block_q[cnt_q] <= bus.in_data;
                        end else if (cnt_q == 4'd12) begin
                            target_q[15:8] <= bus.in_data;
                        end else begin
                            target_q[7:0] <= bus.in_data;
                        end
                        if (cnt_q == 4'd13) begin
                            cnt_q   <= '0;
                            tmr_q   <= '0;
                            state_q <= S_RUN;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_RUN: begin
                    // finish takes priority over a simultaneous expiry.
                    if (finish) begin
                        res_nonce_q   <= {nonce3, nonce2, nonce1, nonce0};
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        start_q       <= 1'b0;
                        state_q       <= S_DONE;
                    end else if (tmr_q == TMAX) begin
                        res_nonce_q   <= '0;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        start_q       <= 1'b0;
                        state_q       <= S_DONE;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q   <= 1'b0;
                        res_timeout_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= S_LOAD;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_job_loader.sv
// Testbench for perf_job_loader: directed frames, scoreboard-checked results.
// Runs with TIMEOUT_CYCLES=16 so the timeout path is reachable quickly.
module tb_perf_job_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        abort;
    logic        finish;
    logic [7:0]  nonce0, nonce1, nonce2, nonce3;
    logic [11:0][7:0] blk;
    logic [15:0] target;
    logic        start;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // {timeout, nonce}
    logic [32:0] exp_q [$];

    perf_job_loader_if bus ();

    perf_job_loader #(
        .TIMEOUT_CYCLES(16),
        .TW(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .abort(abort),
        .block0(blk[0]),
        .block1(blk[1]),
        .block2(blk[2]),
        .block3(blk[3]),
        .block4(blk[4]),
        .block5(blk[5]),
        .block6(blk[6]),
        .block7(blk[7]),
        .block8(blk[8]),
        .block9(blk[9]),
        .block10(blk[10]),
        .block11(blk[11]),
        .target(target),
        .start(start),
        .finish(finish),
        .nonce0(nonce0),
        .nonce1(nonce1),
        .nonce2(nonce2),
        .nonce3(nonce3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every completed result handshake.
    always @(negedge clk) begin
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_result: got %h/%0b expected none",
                         bus.res_nonce, bus.res_timeout);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("res_nonce", bus.res_nonce, e[31:0]);
                chk("res_timeout", {31'd0, bus.res_timeout}, {31'd0, e[32]});
            end
        end
    end

    task automatic send_frame(input logic [7:0] base, input logic [15:0] tgt);
        for (int k = 0; k < 14; k++) begin
            tick();
            bus.in_valid = 1'b1;
            if (k < 12) bus.in_data = base + 8'(k);
            else if (k == 12) bus.in_data = tgt[15:8];
            else bus.in_data = tgt[7:0];
            if (k == 13) begin
                @(negedge clk);
                chk("start_pre", {31'd0, start}, 32'd0);
            end
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("start_post", {31'd0, start}, 32'd1);
        chk("in_ready_run", {31'd0, bus.in_ready}, 32'd0);
        chk("busy_run", {31'd0, busy}, 32'd1);
    endtask

    task automatic check_frame(input logic [7:0] base, input logic [15:0] tgt);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("block%0d", k), {24'd0, blk[k]}, {24'd0, base + 8'(k)});
        end
        chk("target", {16'd0, target}, {16'd0, tgt});
    endtask

    task automatic do_finish(input logic [31:0] n);
        nonce3 = n[31:24];
        nonce2 = n[23:16];
        nonce1 = n[15:8];
        nonce0 = n[7:0];
        finish = 1'b1;
        tick();
        finish = 1'b0;
        @(negedge clk);
        chk("res_valid_up", {31'd0, bus.res_valid}, 32'd1);
        chk("start_down", {31'd0, start}, 32'd0);
    endtask

    task automatic handshake();
        tick();
        bus.res_ready = 1'b1;
        @(negedge clk);
        tick();
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", {31'd0, bus.res_valid}, 32'd0);
        chk("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        chk("busy_drop", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_state();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_timeout", {31'd0, bus.res_timeout}, 32'd0);
        chk("rst_res_nonce", bus.res_nonce, 32'd0);
        chk("rst_block0", {24'd0, blk[0]}, 32'd0);
        chk("rst_block11", {24'd0, blk[11]}, 32'd0);
        chk("rst_target", {16'd0, target}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        abort = 1'b0;
        finish = 1'b0;
        {nonce3, nonce2, nonce1, nonce0} = 32'd0;
        bus.in_data = 8'd0;
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_state();

        // 1: frame 00..0B, target 00FF
        send_frame(8'h00, 16'h00FF);
        check_frame(8'h00, 16'h00FF);

        // 2: found nonce, result held with res_ready low
        repeat (3) tick();
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        do_finish(32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("hold_nonce", bus.res_nonce, 32'hDEADBEEF);
        end
        handshake();

        // 3: timeout after exactly 16 start cycles
        send_frame(8'h10, 16'h4242);
        exp_q.push_back({1'b1, 32'd0});
        n = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.res_valid) break;
            if (start) n++;
        end
        chk("start_cycles", n, 32'd16);
        chk("to_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("to_flag", {31'd0, bus.res_timeout}, 32'd1);
        chk("to_nonce", bus.res_nonce, 32'd0);
        handshake();

        // 4: finish on the last timeout cycle wins
        send_frame(8'h20, 16'h1111);
        repeat (15) tick();
        exp_q.push_back({1'b0, 32'h01020304});
        do_finish(32'h01020304);
        chk("edge_flag", {31'd0, bus.res_timeout}, 32'd0);
        handshake();

        // 5: abort after 7 bytes, then a fresh frame
        for (int k = 0; k < 7; k++) begin
            tick();
            bus.in_valid = 1'b1;
            bus.in_data = 8'hA0 + 8'(k);
        end
        tick();
        abort = 1'b1;
        bus.in_data = 8'hAA;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        abort = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h30, 16'h1234);
        check_frame(8'h30, 16'h1234);

        // 6a: reset mid-RUN, nonce discarded
        repeat (2) tick();
        reset = 1'b1;
        finish = 1'b1;
        nonce0 = 8'h55;
        tick();
        reset = 1'b0;
        finish = 1'b0;
        @(negedge clk);
        check_reset_state();

        // 6b: reset while result is pending
        send_frame(8'h50, 16'hBEEF);
        repeat (2) tick();
        exp_q.push_back({1'b0, 32'h11223344});
        do_finish(32'h11223344);
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_state();

        // 6c: normal job after reset
        send_frame(8'h60, 16'h0F0F);
        check_frame(8'h60, 16'h0F0F);
        repeat (4) tick();
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        do_finish(32'hCAFEF00D);
        handshake();

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
